// File: rtl/apple_spawner.sv
// Apple placement: LFSR-driven random candidates with a sequential scan fallback.
// Candidates are tested live against the snake head and the wall slots.
module apple_spawner #(
    parameter int          ORIGIN_X  = 16,
    parameter int          ORIGIN_Y  = 16,
    parameter int          CELL      = 32,
    parameter int          COLS      = 44,
    parameter int          ROWS      = 27,
    parameter int          NUM_WALLS = 4,
    parameter int          MAX_TRIES = 15,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     btnrst,
    input  logic                     spawn_req,
    input  logic [10:0]              snakehead_x,
    input  logic [10:0]              snakehead_y,
    input  logic [11*NUM_WALLS-1:0]  wall_x,
    input  logic [11*NUM_WALLS-1:0]  wall_y,
    output logic [10:0]              apple_x,
    output logic [10:0]              apple_y,
    output logic                     apple_valid,
    output logic                     busy,
    output logic                     spawn_fail
);

    typedef enum logic [1:0] {IDLE, PICK, CHECK, SCAN} state_t;

    localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
    localparam logic [10:0] OX    = 11'(ORIGIN_X);
    localparam logic [10:0] OY    = 11'(ORIGIN_Y);
    localparam logic [10:0] CW    = 11'(CELL);
    localparam logic [6:0]  NCOL  = 7'(COLS);
    localparam logic [6:0]  NROW  = 7'(ROWS);
    localparam logic [5:0]  LASTC = 6'(COLS - 1);
    localparam logic [5:0]  LASTR = 6'(ROWS - 1);
    localparam logic [7:0]  MAXT  = 8'(MAX_TRIES);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  tries_q, tries_d;
    logic [5:0]  cand_col_q, cand_col_d, cand_row_q, cand_row_d;
    logic [5:0]  scan_col_q, scan_col_d, scan_row_q, scan_row_d;
    logic [10:0] apple_x_q, apple_x_d, apple_y_q, apple_y_d;
    logic        valid_q, valid_d, fail_q, fail_d;

    logic [5:0]  tcol, trow;
    logic [10:0] px, py;
    logic        hit, offgrid;

    // CHECK tests the latched random candidate, SCAN the scan pointer
    always_comb begin
        tcol    = (state_q == SCAN) ? scan_col_q : cand_col_q;
        trow    = (state_q == SCAN) ? scan_row_q : cand_row_q;
        px      = OX + 11'(tcol) * CW;
        py      = OY + 11'(trow) * CW;
        offgrid = ({1'b0, tcol} >= NCOL) || ({1'b0, trow} >= NROW);
    end

    always_comb begin
        hit = (px == snakehead_x) && (py == snakehead_y);
        for (int i = 0; i < NUM_WALLS; i++) begin
            if ((wall_x[11*i +: 11] != 11'h7FF) &&
                (wall_x[11*i +: 11] == px) &&
                (wall_y[11*i +: 11] == py)) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400)
                               : {1'b0, lfsr_q[15:1]};
        tries_d    = tries_q;
        cand_col_d = cand_col_q;
        cand_row_d = cand_row_q;
        scan_col_d = scan_col_q;
        scan_row_d = scan_row_q;
        apple_x_d  = apple_x_q;
        apple_y_d  = apple_y_q;
        valid_d    = valid_q;
        fail_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (spawn_req) begin
                    valid_d = 1'b0;
                    tries_d = 8'd0;
                    state_d = PICK;
                end
            end
            PICK: begin
                cand_col_d = lfsr_q[5:0];
                cand_row_d = lfsr_q[13:8];
                state_d    = CHECK;
            end
            CHECK: begin
                if (offgrid || hit) begin
                    tries_d = tries_q + 8'd1;
                    if (tries_q + 8'd1 == MAXT) begin
                        scan_col_d = 6'd0;
                        scan_row_d = 6'd0;
                        state_d    = SCAN;
                    end else begin
                        state_d = PICK;
                    end
                end else begin
                    apple_x_d = px;
                    apple_y_d = py;
                    valid_d   = 1'b1;
                    state_d   = IDLE;
                end
            end
            SCAN: begin
                if (!hit) begin
                    apple_x_d = px;
                    apple_y_d = py;
                    valid_d   = 1'b1;
                    state_d   = IDLE;
                end else if (scan_col_q == LASTC) begin
                    scan_col_d = 6'd0;
                    if (scan_row_q == LASTR) begin
                        fail_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        scan_row_d = scan_row_q + 6'd1;
                    end
                end else begin
                    scan_col_d = scan_col_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (btnrst) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            tries_q    <= 8'd0;
            cand_col_q <= 6'd0;
            cand_row_q <= 6'd0;
            scan_col_q <= 6'd0;
            scan_row_q <= 6'd0;
            apple_x_q  <= 11'(ORIGIN_X + CELL);
            apple_y_q  <= 11'(ORIGIN_Y);
            valid_q    <= 1'b1;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            tries_q    <= tries_d;
            cand_col_q <= cand_col_d;
            cand_row_q <= cand_row_d;
            scan_col_q <= scan_col_d;
            scan_row_q <= scan_row_d;
            apple_x_q  <= apple_x_d;
            apple_y_q  <= apple_y_d;
            valid_q    <= valid_d;
            fail_q     <= fail_d;
        end
    end

    assign apple_x     = apple_x_q;
    assign apple_y     = apple_y_q;
    assign apple_valid = valid_q;
    assign spawn_fail  = fail_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_apple_spawner.sv
// Directed scoreboard bench for apple_spawner: default grid plus a tiny
// 2x1 grid instance for the scan and no-free-cell paths.
module tb_apple_spawner;

    typedef struct packed {
        logic [10:0] ax;
        logic [10:0] ay;
        logic [15:0] lat;
        logic        fail;
    } exp_t;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        btnrst;
    logic        req_a, req_b;
    logic [10:0] hx_a, hy_a, hx_b, hy_b;
    logic [43:0] wx_a, wy_a;
    logic [10:0] wx_b, wy_b;
    logic [10:0] ax_a, ay_a, ax_b, ay_b;
    logic        valid_a, busy_a, fail_a;
    logic        valid_b, busy_b, fail_b;
    logic [15:0] m;
    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    apple_spawner dut_a (
        .clk(clk), .btnrst(btnrst), .spawn_req(req_a),
        .snakehead_x(hx_a), .snakehead_y(hy_a),
        .wall_x(wx_a), .wall_y(wy_a),
        .apple_x(ax_a), .apple_y(ay_a), .apple_valid(valid_a),
        .busy(busy_a), .spawn_fail(fail_a)
    );

    apple_spawner #(.COLS(2), .ROWS(1), .NUM_WALLS(1), .MAX_TRIES(1)) dut_b (
        .clk(clk), .btnrst(btnrst), .spawn_req(req_b),
        .snakehead_x(hx_b), .snakehead_y(hy_b),
        .wall_x(wx_b), .wall_y(wy_b),
        .apple_x(ax_b), .apple_y(ay_b), .apple_valid(valid_b),
        .busy(busy_b), .spawn_fail(fail_b)
    );

    function automatic logic [15:0] step(input logic [15:0] l);
        return l[0] ? ({1'b0, l[15:1]} ^ 16'hB400) : {1'b0, l[15:1]};
    endfunction

    always @(posedge clk) begin
        if (btnrst) m <= SEED;
        else        m <= step(m);
    end

    function automatic logic blk(input logic [10:0] px, py, hx, hy, wx, wy);
        return ((px == hx) && (py == hy)) ||
               ((wx != 11'h7FF) && (px == wx) && (py == wy));
    endfunction

    // s is the lfsr value at the edge that samples spawn_req
    function automatic exp_t predict(input logic [15:0] s,
                                     input logic [10:0] hx, hy, wx, wy,
                                     input int cols, rows, maxt);
        exp_t e;
        logic [15:0] l;
        logic [10:0] px, py;
        int c, r, j;
        e = '0;
        e.fail = 1'b1;
        l = step(s);
        for (int k = 0; k < maxt; k++) begin
            c  = int'(l[5:0]);
            r  = int'(l[13:8]);
            px = 11'(16 + c * 32);
            py = 11'(16 + r * 32);
            if (c < cols && r < rows && !blk(px, py, hx, hy, wx, wy)) begin
                e.fail = 1'b0;
                e.ax   = px;
                e.ay   = py;
                e.lat  = 16'(3 + 2 * k);
                return e;
            end
            l = step(step(l));
        end
        j = 0;
        for (int rr = 0; rr < rows; rr++) begin
            for (int cc = 0; cc < cols; cc++) begin
                px = 11'(16 + cc * 32);
                py = 11'(16 + rr * 32);
                if (!blk(px, py, hx, hy, wx, wy)) begin
                    e.fail = 1'b0;
                    e.ax   = px;
                    e.ay   = py;
                    e.lat  = 16'(4 + 2 * (maxt - 1) + j);
                    return e;
                end
                j++;
            end
        end
        e.lat = 16'(3 + 2 * (maxt - 1) + cols * rows);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // runs one spawn on the selected instance and scores it
    task automatic spawn(input string tag, input bit sel_b,
                         input logic [15:0] snap);
        exp_t e, g;
        int   n;
        if (sel_b) e = predict(snap, hx_b, hy_b, wx_b, wy_b, 2, 1, 1);
        else       e = predict(snap, hx_a, hy_a, 11'h7FF, 11'h7FF, 44, 27, 15);
        sb.push_back(e);
        if (sel_b) req_b = 1'b1;
        else       req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        req_b = 1'b0;
        n = 1;
        check({tag, "_busy"}, 32'(sel_b ? busy_b : busy_a), 32'd1);
        check({tag, "_vlow"}, 32'(sel_b ? valid_b : valid_a), 32'd0);
        while (!(sel_b ? (valid_b || fail_b) : (valid_a || fail_a)) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        g = sb.pop_front();
        check({tag, "_lat"}, 32'(n), 32'(g.lat));
        check({tag, "_fail"}, 32'(sel_b ? fail_b : fail_a), 32'(g.fail));
        check({tag, "_valid"}, 32'(sel_b ? valid_b : valid_a), 32'(!g.fail));
        check({tag, "_idle"}, 32'(sel_b ? busy_b : busy_a), 32'd0);
        if (!g.fail) begin
            check({tag, "_x"}, 32'(sel_b ? ax_b : ax_a), 32'(g.ax));
            check({tag, "_y"}, 32'(sel_b ? ay_b : ay_a), 32'(g.ay));
        end
    endtask

    initial begin
        exp_t f;
        btnrst = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        hx_a   = 11'd1376;
        hy_a   = 11'd848;
        wx_a   = {4{11'h7FF}};
        wy_a   = {4{11'h7FF}};
        hx_b   = 11'd16;
        hy_b   = 11'd16;
        wx_b   = 11'd48;
        wy_b   = 11'd16;

        // T1 reset
        repeat (2) @(posedge clk);
        #1;
        check("t1_x", 32'(ax_a), 32'd48);
        check("t1_y", 32'(ay_a), 32'd16);
        check("t1_valid", 32'(valid_a), 32'd1);
        check("t1_busy", 32'(busy_a), 32'd0);
        check("t1_fail", 32'(fail_a), 32'd0);
        btnrst = 1'b0;

        // T2 clean spawn straight out of reset: lfsr is the seed
        spawn("t2", 1'b0, SEED);
        check("t2_align_x", 32'((ax_a - 11'd16) % 11'd32), 32'd0);
        check("t2_align_y", 32'((ay_a - 11'd16) % 11'd32), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        spawn("t2b", 1'b0, m);

        // T3 head placed on the first valid candidate
        repeat (2) @(posedge clk);
        #1;
        f = predict(m, 11'd1376, 11'd848, 11'h7FF, 11'h7FF, 44, 27, 15);
        hx_a = f.ax;
        hy_a = f.ay;
        spawn("t3", 1'b0, m);
        check("t3_moved", 32'((ax_a != f.ax) || (ay_a != f.ay)), 32'd1);
        hx_a = 11'd1376;
        hy_a = 11'd848;

        // T4 no free cell on the 2x1 grid
        spawn("t4", 1'b1, m);
        @(posedge clk); #1;
        check("t4_pulse", 32'(fail_b), 32'd0);
        check("t4_vlow", 32'(valid_b), 32'd0);

        // T5 one free cell
        wx_b = 11'h7FF;
        spawn("t5", 1'b1, m);
        check("t5_x", 32'(ax_b), 32'd48);
        check("t5_y", 32'(ay_b), 32'd16);

        // T6 reset while in CHECK
        req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        @(posedge clk); #1;
        check("t6_busy", 32'(busy_a), 32'd1);
        btnrst = 1'b1;
        @(posedge clk); #1;
        btnrst = 1'b0;
        check("t6_x", 32'(ax_a), 32'd48);
        check("t6_y", 32'(ay_a), 32'd16);
        check("t6_valid", 32'(valid_a), 32'd1);
        check("t6_idle", 32'(busy_a), 32'd0);
        check("t6_fail", 32'(fail_a), 32'd0);
        spawn("t6b", 1'b0, SEED);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
